// File: rtl/fft_cplx_fifo_pkg.sv
// Shared FFT constants and width helpers.
// Used by the FIFO, its interface and the radix stages.
package fft_cplx_fifo_pkg;

  localparam int FLOAT_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF  = 3;

  // Packed complex word: {re, im}
  function automatic int cplx_w(input int fl);
    return 2 * fl;
  endfunction

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    for (int i = 0; i < 32; i++) begin
      if (x > 0) begin
        r++;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_cplx_fifo_if.sv
// FIFO bus: flush, write/read requests, data, status flags.
// master drives requests; slave is the FIFO.
interface fft_cplx_fifo_if #(
  parameter int FLOAT_LEN = 32,
  parameter int ADDR_LEN  = 3
);
  import fft_cplx_fifo_pkg::*;

  localparam int DW = cplx_w(FLOAT_LEN);

  logic            clr;
  logic [DW-1:0]   din;
  logic            wr_en;
  logic            rd_en;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [ADDR_LEN:0] count;
  logic            overflow;
  logic            underflow;

  modport master (
    output clr, din, wr_en, rd_en,
    input  dout, dout_valid, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  clr, din, wr_en, rd_en,
    output dout, dout_valid, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fft_cplx_fifo_ram.sv
// Simple dual-port DW x 2**AW array, sync write, registered read.
// Ports: clk, rst (async low, output reg only), we/waddr/wdata, re/raddr/rdata.
module fft_cplx_fifo_ram #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write when both ports hit one address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_cplx_fifo.sv
// Complex-sample FIFO: pointers, count, almost flags, sticky errors.
// Ports: clk, rst (async low), bus (fft_cplx_fifo_if.slave).
module fft_cplx_fifo
  import fft_cplx_fifo_pkg::*;
#(
  parameter int FLOAT_LEN  = FLOAT_LEN_DEF,
  parameter int ADDR_LEN   = ADDR_LEN_DEF,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 1
) (
  input logic           clk,
  input logic           rst,
  fft_cplx_fifo_if.slave bus
);

  localparam int DW    = cplx_w(FLOAT_LEN);
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam int CW    = ADDR_LEN + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_LVL);

  if (ADDR_LEN < 1 || ADDR_LEN > 13 ||
      clog2(DEPTH) != ADDR_LEN) begin : g_bad_addr
    $error("fft_cplx_fifo: ADDR_LEN out of range");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_af
    $error("fft_cplx_fifo: AFULL_LVL out of range");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_bad_ae
    $error("fft_cplx_fifo: AEMPTY_LVL out of range");
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_ptr_n;
  logic [CW-1:0] rd_ptr_n;
  logic [CW-1:0] cnt;
  logic          full_w;
  logic          empty_w;
  logic          rd_ok;
  logic          wr_ok;
  logic          dv;
  logic          ovf;
  logic          udf;
  logic [DW-1:0] rdata;

  assign full_w  = (cnt == FULL_C);
  assign empty_w = (cnt == '0);

  always_comb begin
    rd_ok    = bus.rd_en & ~empty_w & ~bus.clr;
    wr_ok    = bus.wr_en & (~full_w | rd_ok) & ~bus.clr;
    wr_ptr_n = bus.clr ? '0 : wr_ptr + CW'(wr_ok);
    rd_ptr_n = bus.clr ? '0 : rd_ptr + CW'(rd_ok);
  end

  // Count tracks the wrap-bit pointer distance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dv     <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      cnt    <= wr_ptr_n - rd_ptr_n;
      dv     <= rd_ok;
      if (bus.clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (bus.wr_en & full_w & ~rd_ok) ovf <= 1'b1;
        if (bus.rd_en & empty_w)         udf <= 1'b1;
      end
    end
  end

  fft_cplx_fifo_ram #(
    .DW (DW),
    .AW (ADDR_LEN)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_LEN-1:0]),
    .wdata (bus.din),
    .re    (rd_ok),
    .raddr (rd_ptr[ADDR_LEN-1:0]),
    .rdata (rdata)
  );

  assign bus.dout         = rdata;
  assign bus.dout_valid   = dv;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;

endmodule
